// File: rtl/addsub_pipe_pkg.sv
// Shared constants for the add/subtract pipeline: default sizing,
// op-code values and the saturation limits of the WIDTH+1 result.
package addsub_pipe_pkg;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_LATENCY = 3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Largest value a signed (width+1)-bit result can hold: 2^width - 1
    function automatic longint sat_max(input int width);
        sat_max = (longint'(1) << width) - longint'(1);
    endfunction

    // Smallest value a signed (width+1)-bit result can hold: -2^width
    function automatic longint sat_min(input int width);
        sat_min = -(longint'(1) << width);
    endfunction

endpackage

// File: rtl/addsub_if.sv
// Streaming bus of the add/subtract pipeline: operands and mode in,
// result and overflow out, each side with its own valid/ready pair.
interface addsub_if
    import addsub_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] aIn;
    logic [WIDTH-1:0] bIn;
    logic             opSub;
    logic             inValid;
    logic             inReady;
    logic             outValid;
    logic             outReady;
    logic [WIDTH:0]   result;
    logic             overflow;

    // Producer/consumer side that feeds samples and takes results
    modport master (
        output aIn, bIn, opSub, inValid, outReady,
        input  inReady, outValid, result, overflow
    );

    // The pipeline itself
    modport slave (
        input  aIn, bIn, opSub, inValid, outReady,
        output inReady, outValid, result, overflow
    );

endinterface

// File: rtl/addsub_pipe_core.sv
// Combinational arithmetic of the first pipeline stage: operand extension,
// exact add/sub, overflow detection and optional saturation.
module addsub_core
    import addsub_pipe_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int SIGNED_IN = 0,
    parameter int SATURATE  = 0
) (
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             op_sub,
    output logic [WIDTH:0]   result,
    output logic             overflow
);

    localparam longint         SAT_MAX_L   = sat_max(WIDTH);
    localparam longint         SAT_MIN_L   = sat_min(WIDTH);
    localparam logic [WIDTH:0] SAT_MAX_RES = SAT_MAX_L[WIDTH:0];
    localparam logic [WIDTH:0] SAT_MIN_RES = SAT_MIN_L[WIDTH:0];

    logic signed [WIDTH+1:0] a_ext;
    logic signed [WIDTH+1:0] b_ext;
    logic signed [WIDTH+1:0] exact;
    logic                    pos_ovf;
    logic                    neg_ovf;

    // Two guard bits make the sum/difference exact; the top two bits then
    // disagree exactly when the value falls outside the WIDTH+1 signed range
    always_comb begin
        if (SIGNED_IN != 0) begin
            a_ext = {{2{a_in[WIDTH-1]}}, a_in};
            b_ext = {{2{b_in[WIDTH-1]}}, b_in};
        end else begin
            a_ext = {2'b00, a_in};
            b_ext = {2'b00, b_in};
        end

        exact    = (op_sub == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
        pos_ovf  = ~exact[WIDTH+1] &  exact[WIDTH];
        neg_ovf  =  exact[WIDTH+1] & ~exact[WIDTH];
        overflow = pos_ovf | neg_ovf;

        result = exact[WIDTH:0];
        if (SATURATE != 0) begin
            if (pos_ovf) begin
                result = SAT_MAX_RES;
            end else if (neg_ovf) begin
                result = SAT_MIN_RES;
            end
        end
    end

endmodule

// File: rtl/addsub_pipe.sv
// Add/subtract pipeline with valid/ready flow control. Stage 1 does the
// arithmetic; the remaining LATENCY-1 stages are pure delay. The whole
// pipe stalls together whenever the output holds a result nobody takes.
module addsub_pipe
    import addsub_pipe_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int LATENCY   = DEFAULT_LATENCY,
    parameter int SIGNED_IN = 0,
    parameter int SATURATE  = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    addsub_if.slave  bus
);

    logic           advance;
    logic [WIDTH:0] core_result;
    logic           core_overflow;

    logic           valid1_d, valid1_q;
    logic [WIDTH:0] res1_d,   res1_q;
    logic           ovf1_d,   ovf1_q;

    logic           stage_valid [LATENCY];
    logic [WIDTH:0] stage_res   [LATENCY];
    logic           stage_ovf   [LATENCY];

    addsub_core #(
        .WIDTH     (WIDTH),
        .SIGNED_IN (SIGNED_IN),
        .SATURATE  (SATURATE)
    ) u_core (
        .a_in     (bus.aIn),
        .b_in     (bus.bIn),
        .op_sub   (bus.opSub),
        .result   (core_result),
        .overflow (core_overflow)
    );

    assign advance     = bus.outReady | ~stage_valid[LATENCY-1];
    assign bus.inReady = advance;

    // Stage 1 takes a new sample, or a bubble when nothing is offered
    always_comb begin
        valid1_d = valid1_q;
        res1_d   = res1_q;
        ovf1_d   = ovf1_q;
        if (advance) begin
            valid1_d = bus.inValid;
            if (bus.inValid) begin
                res1_d = core_result;
                ovf1_d = core_overflow;
            end
        end
    end

    // Stage 1 registers, cleared asynchronously so in-flight samples vanish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid1_q <= 1'b0;
            res1_q   <= '0;
            ovf1_q   <= 1'b0;
        end else begin
            valid1_q <= valid1_d;
            res1_q   <= res1_d;
            ovf1_q   <= ovf1_d;
        end
    end

    assign stage_valid[0] = valid1_q;
    assign stage_res[0]   = res1_q;
    assign stage_ovf[0]   = ovf1_q;

    for (genvar s = 1; s < LATENCY; s++) begin : g_delay
        logic           valid_d, valid_q;
        logic [WIDTH:0] res_d,   res_q;
        logic           ovf_d,   ovf_q;

        // Shift the previous stage forward on advance, otherwise hold
        always_comb begin
            valid_d = valid_q;
            res_d   = res_q;
            ovf_d   = ovf_q;
            if (advance) begin
                valid_d = stage_valid[s-1];
                res_d   = stage_res[s-1];
                ovf_d   = stage_ovf[s-1];
            end
        end

        // Delay-stage registers with the same asynchronous clear as stage 1
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                res_q   <= '0;
                ovf_q   <= 1'b0;
            end else begin
                valid_q <= valid_d;
                res_q   <= res_d;
                ovf_q   <= ovf_d;
            end
        end

        assign stage_valid[s] = valid_q;
        assign stage_res[s]   = res_q;
        assign stage_ovf[s]   = ovf_q;
    end

    assign bus.outValid = stage_valid[LATENCY-1];
    assign bus.result   = stage_res[LATENCY-1];
    assign bus.overflow = stage_ovf[LATENCY-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: five builds share one stimulus stream
// (default, saturating, signed, LATENCY=1, LATENCY=8).
module tb_addsub_pipe;

    localparam int NDUT = 5;
    localparam int NVEC = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a_in = '0;
    logic [3:0] b_in = '0;
    logic       op_sub = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready  [NDUT];
    logic       out_valid [NDUT];
    logic [4:0] res_o     [NDUT];
    logic       ovf_o     [NDUT];

    int checks = 0;
    int errors = 0;

    addsub_if #(.WIDTH(4)) bus [NDUT] ();

    for (genvar g = 0; g < NDUT; g++) begin : g_wire
        assign bus[g].aIn      = a_in;
        assign bus[g].bIn      = b_in;
        assign bus[g].opSub    = op_sub;
        assign bus[g].inValid  = in_valid;
        assign bus[g].outReady = out_ready;
        assign in_ready[g]     = bus[g].inReady;
        assign out_valid[g]    = bus[g].outValid;
        assign res_o[g]        = bus[g].result;
        assign ovf_o[g]        = bus[g].overflow;
    end

    addsub_pipe #(.WIDTH(4), .LATENCY(3), .SIGNED_IN(0), .SATURATE(0))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus[0]));
    addsub_pipe #(.WIDTH(4), .LATENCY(3), .SIGNED_IN(0), .SATURATE(1))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus[1]));
    addsub_pipe #(.WIDTH(4), .LATENCY(3), .SIGNED_IN(1), .SATURATE(0))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus[2]));
    addsub_pipe #(.WIDTH(4), .LATENCY(1), .SIGNED_IN(0), .SATURATE(0))
        u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus[3]));
    addsub_pipe #(.WIDTH(4), .LATENCY(8), .SIGNED_IN(0), .SATURATE(0))
        u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus[4]));

    always #5 clk = ~clk;

    // Each vector carries hand-computed results for the wrapping unsigned,
    // saturating unsigned and wrapping signed interpretations
    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        int         r_wrap;
        logic       o_wrap;
        int         r_sat;
        logic       o_sat;
        int         r_sgn;
        logic       o_sgn;
    } vec_t;

    // One step of the stall sequence: sample index driven (-1 = none),
    // outReady for the coming edge, expected inReady, expected output index
    typedef struct {
        int   smp;
        logic ordy;
        logic exp_irdy;
        int   exp_out;
    } stall_t;

    vec_t   vecs  [NVEC];
    stall_t steps [12];

    function automatic int lat_of(input int i);
        case (i)
            3:       lat_of = 1;
            4:       lat_of = 8;
            default: lat_of = 3;
        endcase
    endfunction

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 input logic sub, input logic vld, input logic ordy);
        a_in      = a;
        b_in      = b;
        op_sub    = sub;
        in_valid  = vld;
        out_ready = ordy;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            checkOutput($sformatf("%s.dut%0d.outValid", tag, i), int'(out_valid[i]), 0);
            checkOutput($sformatf("%s.dut%0d.result", tag, i), int'(res_o[i]), 0);
            checkOutput($sformatf("%s.dut%0d.overflow", tag, i), int'(ovf_o[i]), 0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{4'd10, 4'd6,  1'b1,   4, 1'b0,   4, 1'b0, -12, 1'b0};
        vecs[1] = '{4'd5,  4'd8,  1'b1,  -3, 1'b0,  -3, 1'b0,  13, 1'b0};
        vecs[2] = '{4'd3,  4'd3,  1'b1,   0, 1'b0,   0, 1'b0,   0, 1'b0};
        vecs[3] = '{4'd15, 4'd15, 1'b0,  -2, 1'b1,  15, 1'b1,  -2, 1'b0};
        vecs[4] = '{4'd8,  4'd7,  1'b1,   1, 1'b0,   1, 1'b0, -15, 1'b0};
        vecs[5] = '{4'd8,  4'd8,  1'b0, -16, 1'b1,  15, 1'b1, -16, 1'b0};
        vecs[6] = '{4'd0,  4'd15, 1'b1, -15, 1'b0, -15, 1'b0,   1, 1'b0};
        vecs[7] = '{4'd7,  4'd7,  1'b0,  14, 1'b0,  14, 1'b0,  14, 1'b0};
        vecs[8] = '{4'd9,  4'd7,  1'b0, -16, 1'b1,  15, 1'b1,   0, 1'b0};
        vecs[9] = '{4'd1,  4'd15, 1'b1, -14, 1'b0, -14, 1'b0,   2, 1'b0};

        steps[0]  = '{ 0, 1'b1, 1'b1, -1};
        steps[1]  = '{ 1, 1'b1, 1'b1, -1};
        steps[2]  = '{ 2, 1'b1, 1'b1,  0};
        steps[3]  = '{ 3, 1'b0, 1'b0,  0};
        steps[4]  = '{ 3, 1'b0, 1'b0,  0};
        steps[5]  = '{ 3, 1'b0, 1'b0,  0};
        steps[6]  = '{ 3, 1'b0, 1'b0,  0};
        steps[7]  = '{ 3, 1'b1, 1'b1,  1};
        steps[8]  = '{ 4, 1'b1, 1'b1,  2};
        steps[9]  = '{-1, 1'b1, 1'b1,  3};
        steps[10] = '{-1, 1'b1, 1'b1,  4};
        steps[11] = '{-1, 1'b1, 1'b1, -1};

        // Power-on reset: everything quiet while rst_n is low
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkIdle("reset");
        rst_n = 1'b1;

        // Back-to-back vectors; each build sees sample e-(LATENCY-1) after edge e
        for (int e = 0; e < NVEC + 8; e++) begin
            if (e < NVEC)
                applyStimulus(vecs[e].a, vecs[e].b, vecs[e].sub, 1'b1, 1'b1);
            else
                applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
            @(posedge clk);
            #1;
            for (int i = 0; i < NDUT; i++) begin
                int   idx;
                int   exp_r;
                logic exp_o;
                idx = e - (lat_of(i) - 1);
                if (idx >= 0 && idx < NVEC) begin
                    exp_r = (i == 1) ? vecs[idx].r_sat : (i == 2) ? vecs[idx].r_sgn : vecs[idx].r_wrap;
                    exp_o = (i == 1) ? vecs[idx].o_sat : (i == 2) ? vecs[idx].o_sgn : vecs[idx].o_wrap;
                    checkOutput($sformatf("vec%0d.dut%0d.outValid", idx, i), int'(out_valid[i]), 1);
                    checkOutput($sformatf("vec%0d.dut%0d.result", idx, i), int'($signed(res_o[i])), exp_r);
                    checkOutput($sformatf("vec%0d.dut%0d.overflow", idx, i), int'(ovf_o[i]), int'(exp_o));
                end else begin
                    checkOutput($sformatf("edge%0d.dut%0d.idle", e, i), int'(out_valid[i]), 0);
                end
            end
        end

        // Mid-stream stall on the default build: sample k is k*3 + 1
        for (int t = 0; t < 12; t++) begin
            if (steps[t].smp >= 0)
                applyStimulus(4'(steps[t].smp * 3), 4'd1, 1'b0, 1'b1, steps[t].ordy);
            else
                applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, steps[t].ordy);
            #1;
            checkOutput($sformatf("stall%0d.inReady", t), int'(in_ready[0]), int'(steps[t].exp_irdy));
            @(posedge clk);
            #1;
            checkOutput($sformatf("stall%0d.outValid", t), int'(out_valid[0]), (steps[t].exp_out >= 0) ? 1 : 0);
            if (steps[t].exp_out >= 0)
                checkOutput($sformatf("stall%0d.result", t), int'($signed(res_o[0])), steps[t].exp_out * 3 + 1);
        end

        // Fill the default build so a result is showing, then reset mid-cycle
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'(k + 4), 4'd1, 1'b0, 1'b1, 1'b1);
            @(posedge clk);
            #1;
        end
        checkOutput("prereset.outValid", int'(out_valid[0]), 1);
        checkOutput("prereset.result", int'($signed(res_o[0])), 5);
        rst_n = 1'b0;
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        #1;
        checkIdle("midreset");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("inreset.outValid", int'(out_valid[0]), 0);
        rst_n = 1'b1;

        // First edge after release accepts even with outReady low; 2 - 3 = -1
        applyStimulus(4'd2, 4'd3, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("release.inReady", int'(in_ready[0]), 1);
        @(posedge clk);
        #1;
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("release.edge0.outValid", int'(out_valid[0]), 0);
        @(posedge clk);
        #1;
        checkOutput("release.edge1.outValid", int'(out_valid[0]), 0);
        @(posedge clk);
        #1;
        checkOutput("release.edge2.outValid", int'(out_valid[0]), 1);
        checkOutput("release.edge2.result", int'($signed(res_o[0])), -1);
        checkOutput("release.edge2.overflow", int'(ovf_o[0]), 0);
        checkOutput("release.held.inReady", int'(in_ready[0]), 0);
        @(posedge clk);
        #1;
        checkOutput("release.held.outValid", int'(out_valid[0]), 1);
        checkOutput("release.held.result", int'($signed(res_o[0])), -1);
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("release.drained.outValid", int'(out_valid[0]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
